mem_stage_lsu: RTL

- Parametrised load/store unit for the MEM pipeline stage. It sits between the EX/MEM bus and the D-cache and feeds the MEM/WB bus.
- Supports byte, halfword and word accesses, with per-lane byte enables, store-data replication and load sign/zero extension.
- A request FSM holds the D-cache request stable until `dcache_ready_in`, drives `mem_stall_out` to the Hazard Unit, and aborts with a bus error on a wait-timeout.

---
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - D-cache request/response bus between the MEM-stage LSU and the data cache
interface mem_stage_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              dcache_en_read_out;
   logic              dcache_en_write_out;
   logic [3:0]        dcache_byte_en_out;
   logic [ADDR_W-1:0] dcache_addr_out;
   logic [31:0]       dcache_wdata_out;
   logic [31:0]       dcache_rdata_in;
   logic              dcache_ready_in;

   modport master (
      output dcache_en_read_out, dcache_en_write_out, dcache_byte_en_out,
             dcache_addr_out, dcache_wdata_out,
      input  dcache_rdata_in, dcache_ready_in
   );

   modport slave (
      input  dcache_en_read_out, dcache_en_write_out, dcache_byte_en_out,
             dcache_addr_out, dcache_wdata_out,
      output dcache_rdata_in, dcache_ready_in
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with D-cache request FSM and wait timeout
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter int          ADDR_W   = 32,
   parameter int          REG_W    = 5,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] alu_result_in,
   input  logic [31:0]       reg_data2_in,
   input  logic [REG_W-1:0]  dest_reg_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [1:0]        mem_size_in,
   input  logic              mem_unsigned_in,
   input  logic              mem_to_reg_in,
   input  logic              reg_write_in,
   mem_stage_lsu_if.master   dc,
   output logic [31:0]       mem_data_out,
   output logic [ADDR_W-1:0] alu_result_out,
   output logic [REG_W-1:0]  dest_reg_out,
   output logic              mem_to_reg_out,
   output logic              reg_write_out,
   output logic              mem_stall_out,
   output logic              bus_err_out,
   output logic              misalign_exc_out
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d, rd_q, rd_d, wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d, load_data_q, load_data_d;
   logic [3:0]        be_q, be_d;
   logic              err_q, err_d, mis_q, mis_d;

   logic              mop, trap, timeout_hit, in_access, in_done;
   logic [1:0]        a;
   logic [3:0]        be_in;
   logic [31:0]       wdata_in, ext;
   logic [7:0]        b_sel;
   logic [15:0]       h_sel;

   assign mop = mem_read_in | mem_write_in;
   assign a   = alu_result_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = mop & ((mem_size_in == 2'b01) ? a[0] : ((mem_size_in == 2'b00) ? 1'b0 : |a));
`else
   assign trap = 1'b0;
`endif

   // Lane enables only look at the alignment-relevant address bits.
   always_comb begin
      be_in    = 4'b1111;
      wdata_in = reg_data2_in;
      case (mem_size_in)
         2'b00: begin
            be_in    = 4'b0001 << a;
            wdata_in = {4{reg_data2_in[7:0]}};
         end
         2'b01: begin
            be_in    = a[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{reg_data2_in[15:0]}};
         end
         default: begin
            be_in    = 4'b1111;
            wdata_in = reg_data2_in;
         end
      endcase
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    b_sel = dc.dcache_rdata_in[7:0];
         2'd1:    b_sel = dc.dcache_rdata_in[15:8];
         2'd2:    b_sel = dc.dcache_rdata_in[23:16];
         default: b_sel = dc.dcache_rdata_in[31:24];
      endcase
      h_sel = addr_q[1] ? dc.dcache_rdata_in[31:16] : dc.dcache_rdata_in[15:0];
      case (size_q)
         2'b00:   ext = {{24{b_sel[7] & ~uns_q}}, b_sel};
         2'b01:   ext = {{16{h_sel[15] & ~uns_q}}, h_sel};
         default: ext = dc.dcache_rdata_in;
      endcase
   end

   assign timeout_hit = (MAX_WAIT != 0) && ((32'(wait_q) + 32'd1) == MAX_WAIT);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      load_data_d = load_data_q;
      err_d       = err_q;
      mis_d       = mis_q;
      case (state_q)
         S_IDLE: begin
            if (mop) begin
               addr_d  = alu_result_in;
               size_d  = mem_size_in;
               uns_d   = mem_unsigned_in;
               wr_d    = mem_write_in;
               rd_d    = ~mem_write_in;
               wdata_d = wdata_in;
               be_d    = be_in;
               wait_d  = '0;
               err_d   = 1'b0;
               mis_d   = trap;
               state_d = trap ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            wait_d = wait_q + CW'(1);
            // Ready on the final allowed cycle still wins over the timeout.
            if (dc.dcache_ready_in) begin
               if (rd_q) load_data_d = ext;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         addr_q      <= '0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         be_q        <= 4'b0000;
         load_data_q <= '0;
         err_q       <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
         mis_q       <= mis_d;
      end
   end

   // Outputs are gated by rst_n so a reset drops the request in the same cycle.
   assign in_access = rst_n & (state_q == S_ACCESS);
   assign in_done   = rst_n & (state_q == S_DONE);

   assign dc.dcache_en_read_out  = in_access & rd_q;
   assign dc.dcache_en_write_out = in_access & wr_q;
   assign dc.dcache_byte_en_out  = in_access ? be_q : 4'b0000;
   assign dc.dcache_addr_out     = addr_q;
   assign dc.dcache_wdata_out    = wdata_q;

   assign mem_stall_out    = rst_n & (((state_q == S_IDLE) & mop) | (state_q == S_ACCESS));
   assign bus_err_out      = in_done & err_q & ~mis_q;
   assign misalign_exc_out = in_done & mis_q;
   assign mem_data_out     = (in_done & ~mis_q) ? load_data_q : 32'd0;
   assign reg_write_out    = reg_write_in & ~((state_q == S_DONE) & (err_q | mis_q));

   assign alu_result_out = alu_result_in;
   assign dest_reg_out   = dest_reg_in;
   assign mem_to_reg_out = mem_to_reg_in;
endmodule
